axis_rr_arbiter: RTL and testbench

//  N-to-1 AXI-Stream packet arbiter, successor to the fixed 2-input arbiter.

---
 rtl/axis_arb_pkg.sv | 13 +
 rtl/axis_skid_buf.sv | 45 ++++
 rtl/axis_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_axis_rr_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the round-robin AXI-Stream packet arbiter.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry elastic buffer; in_ready is decoded from the occupancy register only,
// so there is no combinational path from out_ready back to in_ready.
module axis_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI-Stream packet arbiter: round-robin grant held for a whole packet.
// Optional m_axis_tid output (source index per beat) enabled by AXIS_ARB_TID_EN.
//
//   state    | meaning
//   ARB_IDLE | no grant; pick next requester after last grant
//   ARB_BUSY | grant locked to one port until its tlast beat is accepted
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int DATA_W    = 32,
  localparam int IDX_W     = clog2_min1(NUM_PORTS)
) (
  input  logic                        axis_aclk,
  input  logic                        axis_areset,
  input  logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
  output logic [NUM_PORTS-1:0]        s_axis_tready,
  input  logic [NUM_PORTS-1:0]        s_axis_tlast,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
`ifdef AXIS_ARB_TID_EN
  ,
  output logic [IDX_W-1:0]            m_axis_tid
`endif
);

`ifdef AXIS_ARB_TID_EN
  localparam int BUF_W = DATA_W + 1 + IDX_W;
`else
  localparam int BUF_W = DATA_W + 1;
`endif

  arb_state_e       state;
  arb_state_e       state_nxt;
  // grant doubles as last_grant: it keeps the previous winner while idle
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] idx_c;
  logic             found;
  logic             any_req;
  logic             buf_ready;
  logic             in_valid;
  logic             beat_acc;
  logic [BUF_W-1:0] buf_in;
  logic [BUF_W-1:0] buf_out;
  logic [DATA_W-1:0] s_data [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
    assign s_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];
  end

  assign any_req = |s_axis_tvalid;

  always_comb begin
    pick  = grant;
    idx_c = grant;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx_c = IDX_W'((int'(grant) + k) % NUM_PORTS);
      if (!found && s_axis_tvalid[idx_c]) begin
        pick  = idx_c;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state <= ARB_IDLE;
      grant <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && any_req) grant <= pick;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (any_req) state_nxt = ARB_BUSY;
      ARB_BUSY: if (beat_acc && s_axis_tlast[grant]) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    in_valid      = 1'b0;
    if (state == ARB_BUSY) begin
      s_axis_tready[grant] = buf_ready;
      in_valid             = s_axis_tvalid[grant];
    end
  end

  assign beat_acc = in_valid & buf_ready;

`ifdef AXIS_ARB_TID_EN
  assign buf_in     = {grant, s_axis_tlast[grant], s_data[grant]};
  assign m_axis_tid = buf_out[BUF_W-1 -: IDX_W];
`else
  assign buf_in     = {s_axis_tlast[grant], s_data[grant]};
`endif

  assign m_axis_tdata = buf_out[DATA_W-1:0];
  assign m_axis_tlast = buf_out[DATA_W];

  axis_skid_buf #(
    .WIDTH (BUF_W)
  ) u_skid (
    .clk       (axis_aclk),
    .rst       (axis_areset),
    .in_data   (buf_in),
    .in_valid  (in_valid),
    .in_ready  (buf_ready),
    .out_data  (buf_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: per-port packet producers, a packet-level
// round-robin model that fills the expected queue, and an output monitor.
module tb_axis_rr_arbiter;

  localparam int NP    = 4;
  localparam int DW    = 32;
  localparam int IW    = 2;
  localparam int DEPTH = 1200;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP*DW-1:0] s_tdata = '0;
  logic [NP-1:0]    s_tvalid = '0;
  logic [NP-1:0]    s_tready;
  logic [NP-1:0]    s_tlast = '0;
  logic [DW-1:0]    m_data;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic             m_last;
`ifdef AXIS_ARB_TID_EN
  logic [IW-1:0]    m_tid;
`endif

  always #5 clk = ~clk;

  axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .axis_aclk     (clk),
    .axis_areset   (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tlast  (m_last)
`ifdef AXIS_ARB_TID_EN
    ,
    .m_axis_tid    (m_tid)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            port;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  logic [DW-1:0] p_data [NP][DEPTH];
  logic          p_last [NP][DEPTH];
  int            p_gap  [NP][DEPTH];
  int            p_cnt  [NP];
  int            p_idx  [NP];
  int            p_gap_left [NP];
  bit            acc [NP];

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  model_last = NP - 1;
  bit  rnd_ready = 1'b0;
  bit  check_timing = 1'b0;
  int  last_out_cyc = -1;
  int  first_cyc = -1;
  bit  last_was_tlast = 1'b0;
  bit  prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic add_pkt(input int p, input int len, input logic [DW-1:0] base, input bit rnd);
    for (int b = 0; b < len; b++) begin
      p_data[p][p_cnt[p]] = rnd ? DW'($urandom) : base + DW'(b);
      p_last[p][p_cnt[p]] = (b == len - 1);
      p_gap[p][p_cnt[p]]  = (b == 0 || !rnd) ? 0 :
                            (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      p_cnt[p]++;
    end
  endtask

  task automatic clear_ports();
    for (int p = 0; p < NP; p++) begin
      p_cnt[p] = 0;
      p_idx[p] = 0;
      p_gap_left[p] = 0;
    end
  endtask

  // Packet-level round robin: every port with packets left competes at each boundary.
  task automatic build_expected();
    int  mp [NP];
    bit  found;
    int  p;
    for (int i = 0; i < NP; i++) mp[i] = p_idx[i];
    do begin
      found = 1'b0;
      for (int k = 1; k <= NP && !found; k++) begin
        p = (model_last + k) % NP;
        if (mp[p] < p_cnt[p]) begin
          bit done;
          done = 1'b0;
          while (!done) begin
            exp_q.push_back('{data: p_data[p][mp[p]], last: p_last[p][mp[p]], port: p});
            done = p_last[p][mp[p]];
            mp[p]++;
          end
          model_last = p;
          found = 1'b1;
        end
      end
    end while (found);
    last_out_cyc = -1;
    first_cyc = -1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #2;
  endtask

  // Producers: a beat advances when it was handshaked at the preceding edge.
  initial begin
    clear_ports();
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) acc[p] = s_tvalid[p] & s_tready[p];
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p]) begin
          p_idx[p]++;
          if (p_idx[p] < p_cnt[p]) p_gap_left[p] = p_gap[p][p_idx[p]];
        end
        if (p_gap_left[p] > 0) begin
          s_tvalid[p] = 1'b0;
          p_gap_left[p]--;
        end else begin
          s_tvalid[p] = (p_idx[p] < p_cnt[p]);
        end
        if (p_idx[p] < p_cnt[p]) begin
          s_tdata[p*DW +: DW] = p_data[p][p_idx[p]];
          s_tlast[p] = p_last[p][p_idx[p]];
        end else begin
          s_tlast[p] = 1'b0;
        end
      end
      m_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        check("tready_onehot", 64'($countones(s_tready) <= 1), 64'd1);
        if (prev_stall) begin
          check("stall_valid", 64'(m_valid), 64'd1);
          check("stall_data", 64'(m_data), 64'(prev_data));
          check("stall_last", 64'(m_last), 64'(prev_last));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(m_data), 64'hDEAD_0000_0000);
          end else begin
            e = exp_q.pop_front();
            check("data", 64'(m_data), 64'(e.data));
            check("last", 64'(m_last), 64'(e.last));
`ifdef AXIS_ARB_TID_EN
            check("tid", 64'(m_tid), 64'(e.port));
`endif
          end
          if (check_timing && last_out_cyc >= 0)
            check("beat_spacing", 64'(cyc - last_out_cyc), last_was_tlast ? 64'd2 : 64'd1);
          if (last_out_cyc < 0) first_cyc = cyc;
          last_out_cyc   = cyc;
          last_was_tlast = m_last;
        end
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  initial begin
    int load_c;
    int total;
    int n;

    // Reset held with every port requesting, then plain round robin with bubbles.
    rst = 1'b1;
    #2;
    for (int p = 0; p < NP; p++) add_pkt(p, 3, DW'((p << 8) | 8'h10), 1'b0);
    add_pkt(0, 3, DW'(32'h0020), 1'b0);
    model_last = NP - 1;
    build_expected();
    check("order_first_port0", 64'(exp_q[0].port), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_tready", 64'(s_tready), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    check_timing = 1'b1;
    drain("rr_all");

    // Port 1 stalls mid-packet while port 3 waits.
    check_timing = 1'b0;
    clear_ports();
    add_pkt(1, 4, DW'(32'h0100), 1'b0);
    p_gap[1][1] = 4;
    add_pkt(3, 2, DW'(32'h0300), 1'b0);
    build_expected();
    check("hold_grant_order", 64'(exp_q[0].port), 64'd1);
    drain("hold_grant");

    // Single requester, also checks the request-to-output latency.
    clear_ports();
    check_timing = 1'b1;
    load_c = cyc;
    add_pkt(2, 5, DW'(32'hA0), 1'b0);
    build_expected();
    drain("port2_only");
    check("latency_first_beat", 64'(first_cyc), 64'(load_c + 4));

    // Randomised traffic and backpressure.
    check_timing = 1'b0;
    clear_ports();
    rnd_ready = 1'b1;
    total = 0;
    while (total < 1000) begin
      int p;
      int len;
      p   = $urandom_range(0, NP - 1);
      len = $urandom_range(1, 8);
      add_pkt(p, len, '0, 1'b1);
      total += len;
    end
    build_expected();
    drain("random");
    rnd_ready = 1'b0;

    // Reset in the middle of a port 0 packet.
    clear_ports();
    add_pkt(0, 8, DW'(32'h0800), 1'b0);
    build_expected();
    n = 0;
    while (exp_q.size() > 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("midpkt_progress", 64'(exp_q.size() <= 5), 64'd1);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    clear_ports();
    exp_q.delete();
    @(negedge clk);
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_tready", 64'(s_tready), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_last = NP - 1;
    add_pkt(2, 2, DW'(32'h0C00), 1'b0);
    add_pkt(0, 2, DW'(32'h0D00), 1'b0);
    build_expected();
    check("after_rst_port0", 64'(exp_q[0].port), 64'd0);
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
